reg_read_decoder: RTL

REG_READ_DECODER -- requirements
Module: reg_read_decoder

---
 rtl/regfile_pkg.sv | 13 +
 rtl/read_decoder_n.sv | 15 +
 rtl/reg_read_decoder.sv | 117 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file read decoder: default register-ID
// width and the sweep FSM state type.
package regfile_pkg;

  localparam int DEFAULT_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/read_decoder_n.sv
// Combinational ADDR_W -> 2**ADDR_W one-hot decoder; all-zero when not enabled.
module read_decoder_n #(
  parameter int ADDR_W = 4
) (
  input  logic                     en,
  input  logic [ADDR_W-1:0]        id,
  output logic [(1<<ADDR_W)-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[id] = 1'b1;
  end

endmodule

// File: rtl/reg_read_decoder.sv
// Multi-port registered wordline decoder with a port-0 full-register sweep FSM.
// Optional read-after-write bypass flags are built when REG_READ_BYPASS_EN is defined.
module reg_read_decoder
  import regfile_pkg::*;
#(
  parameter  int ADDR_W    = DEFAULT_ADDR_W,
  parameter  int NUM_PORTS = 2,
  localparam int DEPTH     = 1 << ADDR_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                stall,
  input  logic [NUM_PORTS-1:0]                rd_en,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    rd_id,
  input  logic                                wr_en,
  input  logic [ADDR_W-1:0]                   wr_id,
  input  logic                                scan_start,
  output logic [NUM_PORTS-1:0][DEPTH-1:0]     wordline,
  output logic [NUM_PORTS-1:0]                rd_valid,
  output logic [NUM_PORTS-1:0]                bypass,
  output logic                                scan_busy,
  output logic                                scan_done
);

  scan_state_e                          state_q, state_d;
  logic [ADDR_W-1:0]                    cnt_q, cnt_d;
  logic [NUM_PORTS-1:0][DEPTH-1:0]      wordline_q, wordline_d;
  logic [NUM_PORTS-1:0]                 rd_valid_q, rd_valid_d;
  logic [NUM_PORTS-1:0]                 dec_en;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]     dec_id;
  logic                                 scan_active;

  assign scan_active = (state_q == SCAN);

  // The sweep takes over port 0's decoder input; other ports are untouched.
  always_comb begin
    dec_en = rd_en;
    dec_id = rd_id;
    if (scan_active) begin
      dec_en[0] = 1'b1;
      dec_id[0] = cnt_q;
    end
  end

  assign rd_valid_d = dec_en;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    read_decoder_n #(.ADDR_W(ADDR_W)) u_dec (
      .en     (dec_en[p]),
      .id     (dec_id[p]),
      .onehot (wordline_d[p])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (scan_start) begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        // Counter parks on the last ID rather than wrapping.
        if (&cnt_q) state_d = DONE;
        else        cnt_d   = cnt_q + ADDR_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wordline_q <= '0;
      rd_valid_q <= '0;
    end else if (!stall) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wordline_q <= wordline_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign wordline  = wordline_q;
  assign rd_valid  = rd_valid_q;
  assign scan_busy = (state_q == SCAN);
  assign scan_done = (state_q == DONE);

`ifdef REG_READ_BYPASS_EN
  logic [NUM_PORTS-1:0] bypass_q, bypass_d;

  always_comb begin
    bypass_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      bypass_d[p] = rd_en[p] & wr_en & (rd_id[p] == wr_id);
    end
    if (scan_active) bypass_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bypass_q <= '0;
    else if (!stall) bypass_q <= bypass_d;
  end

  assign bypass = bypass_q;
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_id};
  assign bypass    = '0;
`endif

endmodule
